// File: rtl/wave_pkg.sv
// Shared definitions for the PWM audio DAC: FSM state codes, source select
// codes and the fixed midscale duty value.
package wave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_SIN  = 2'd0,
    SEL_FULL = 2'd1,
    SEL_HALF = 2'd2,
    SEL_MID  = 2'd3
  } sel_t;

  localparam logic [7:0] MIDSCALE = 8'd127;
  localparam logic [7:0] PWM_LAST = 8'd255;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by PRESCALE while run is high; tick marks the last count of
// each division and the counter wraps to zero on it.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_reg;

  assign tick = run && (count_reg == LAST);

  // Held at zero whenever not running so every new run starts aligned.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/wave_pwm_dac.sv
// PWM DAC: latches an 8-bit duty from the selected waveform source at the
// start of each 256-tick period and compares it against the PWM counter.
module wave_pwm_dac
  import wave_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] sel,
  input  logic [7:0] sinWave,
  input  logic [7:0] fullRectifiedWave,
  input  logic [7:0] halfRectifiedWave,
  output logic       pwmOut,
  output logic       sampleTick,
  output logic [7:0] dutyHeld,
  output logic       busy
);

  state_t     state_reg, state_next;
  logic [7:0] pwm_cnt_reg;
  logic [7:0] duty_reg;
  logic       sample_tick_reg;
  logic       tick;
  logic       period_end;
  logic       latch;
  logic [7:0] src_value;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (state_reg != ST_IDLE),
    .tick (tick)
  );

  assign period_end = tick && (pwm_cnt_reg == PWM_LAST);

  always_comb begin
    src_value = MIDSCALE;
    case (sel_t'(sel))
      SEL_SIN:  src_value = sinWave;
      SEL_FULL: src_value = fullRectifiedWave;
      SEL_HALF: src_value = halfRectifiedWave;
      default:  src_value = MIDSCALE;
    endcase
  end

  // Leaving RUN only arms DRAIN; the period always runs to its end first.
  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_RUN;
          latch      = 1'b1;
        end
      end
      ST_RUN: begin
        if (period_end) latch = 1'b1;
        if (!enable) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable) begin
          state_next = ST_RUN;
          if (period_end) latch = 1'b1;
        end else if (period_end) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      pwm_cnt_reg     <= '0;
      duty_reg        <= '0;
      sample_tick_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sample_tick_reg <= latch;
      if (latch) duty_reg <= src_value;
      if (state_reg == ST_IDLE) begin
        pwm_cnt_reg <= '0;
      end else if (tick) begin
        pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      end
    end
  end

  assign pwmOut     = (state_reg != ST_IDLE) && (pwm_cnt_reg < duty_reg);
  assign busy       = (state_reg != ST_IDLE);
  assign sampleTick = sample_tick_reg;
  assign dutyHeld   = duty_reg;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Self-checking bench for wave_pwm_dac: measures whole PWM periods and
// compares high-time, period length and latched duty against a source model.
module tb_wave_pwm_dac;

  logic       clk = 1'b0;
  logic       rst, enable, rst4, en4;
  logic [1:0] sel, sel4;
  logic [7:0] sinWave, fullRectifiedWave, halfRectifiedWave;
  logic       pwmOut, sampleTick, busy;
  logic [7:0] dutyHeld;
  logic       pwm4, st4, busy4;
  logic [7:0] duty4;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_duty;
  int period_no = 0;

  always #5 clk = ~clk;

  wave_pwm_dac #(.PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sel(sel),
    .sinWave(sinWave), .fullRectifiedWave(fullRectifiedWave),
    .halfRectifiedWave(halfRectifiedWave),
    .pwmOut(pwmOut), .sampleTick(sampleTick), .dutyHeld(dutyHeld), .busy(busy)
  );

  wave_pwm_dac #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst4), .enable(en4), .sel(sel4),
    .sinWave(sinWave), .fullRectifiedWave(fullRectifiedWave),
    .halfRectifiedWave(halfRectifiedWave),
    .pwmOut(pwm4), .sampleTick(st4), .dutyHeld(duty4), .busy(busy4)
  );

  function automatic logic [7:0] src_model(input logic [1:0] s, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] c);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return 8'd127;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Runs from a sampleTick cycle to the next one, switching source inputs at chg_at.
  task automatic measure(input int chg_at, input logic [1:0] nsel, input logic [7:0] ns,
                         input logic [7:0] nf, input logic [7:0] nh,
                         output int high, output int len);
    high = 0;
    len  = 0;
    do begin
      if (pwmOut === 1'b1) high++;
      len++;
      if (len == chg_at) begin
        sel = nsel; sinWave = ns; fullRectifiedWave = nf; halfRectifiedWave = nh;
      end
      step();
    end while (sampleTick !== 1'b1 && len < 1000);
  endtask

  task automatic period_check(input int chg_at, input logic [1:0] nsel, input logic [7:0] ns,
                              input logic [7:0] nf, input logic [7:0] nh);
    int high, len;
    logic [7:0] nxt;
    nxt = src_model(nsel, ns, nf, nh);
    measure(chg_at, nsel, ns, nf, nh, high, len);
    $display("period %0d: duty %0d high %0d len %0d, next duty %0d", period_no, exp_duty, high, len, nxt);
    check("period_high", high, exp_duty);
    check("period_len", len, 256);
    check("relatch_duty", dutyHeld, nxt);
    exp_duty = nxt;
    period_no++;
  endtask

  initial begin
    int high, mism, t;
    logic busy_drop;
    logic exp_out;

    rst = 1'b1; rst4 = 1'b1; enable = 1'b0; en4 = 1'b0; sel = 2'd0; sel4 = 2'd3;
    sinWave = 8'd0; fullRectifiedWave = 8'd0; halfRectifiedWave = 8'd0;
    step(); step();
    check("rst_pwm", pwmOut, 1'b0);
    check("rst_duty", dutyHeld, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_tick", sampleTick, 1'b0);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 1'b0);

    // Start with sine sample 64
    sinWave = 8'd64; enable = 1'b1;
    step();
    check("start_tick", sampleTick, 1'b1);
    check("start_duty", dutyHeld, 8'd64);
    check("start_busy", busy, 1'b1);
    exp_duty = 8'd64;

    period_check(10, 2'd0, 8'd0,   8'd0, 8'd0);
    period_check(10, 2'd0, 8'd1,   8'd0, 8'd0);
    period_check(10, 2'd0, 8'd255, 8'd0, 8'd0);
    period_check(10, 2'd2, 8'd255, 8'd0, 8'd200);
    period_check(10, 2'd0, 8'd9,   8'd0, 8'd200);
    for (int k = 0; k < 5; k++) begin
      period_check(int'($urandom_range(1, 250)), 2'($urandom_range(0, 3)),
                   8'($urandom), 8'($urandom), 8'($urandom));
    end

    // Drop enable at count 100 and reassert at 150: period must continue seamlessly
    high = 0; busy_drop = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (pwmOut === 1'b1) high++;
      if (busy !== 1'b1) busy_drop = 1'b1;
      if (i == 100) enable = 1'b0;
      if (i == 150) enable = 1'b1;
      step();
    end
    $display("reassert period: high %0d duty %0d", high, exp_duty);
    check("reassert_high", high, exp_duty);
    check("reassert_busy", busy_drop, 1'b0);
    check("reassert_relatch", sampleTick, 1'b1);

    // Drop enable at count 100: period finishes then IDLE with duty retained
    high = 0; busy_drop = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (pwmOut === 1'b1) high++;
      if (busy !== 1'b1) busy_drop = 1'b1;
      if (i == 100) enable = 1'b0;
      step();
    end
    $display("drain period: high %0d duty %0d busy_after %0d", high, exp_duty, busy);
    check("drain_high", high, exp_duty);
    check("drain_busy_during", busy_drop, 1'b0);
    check("drain_idle_busy", busy, 1'b0);
    check("drain_no_tick", sampleTick, 1'b0);
    check("drain_duty_kept", dutyHeld, exp_duty);
    check("drain_pwm_low", pwmOut, 1'b0);

    // Reset mid-period with duty 128
    sel = 2'd0; sinWave = 8'd128; enable = 1'b1;
    step();
    check("d128_duty", dutyHeld, 8'd128);
    for (int i = 0; i < 30; i++) step();
    check("d128_pwm_cnt30", pwmOut, 1'b1);
    rst = 1'b1;
    step();
    $display("mid-period reset: pwm %0d duty %0d busy %0d tick %0d", pwmOut, dutyHeld, busy, sampleTick);
    check("midrst_pwm", pwmOut, 1'b0);
    check("midrst_duty", dutyHeld, 8'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tick", sampleTick, 1'b0);
    step();
    check("rst_priority_busy", busy, 1'b0);
    rst = 1'b0;
    step();
    check("resume_busy", busy, 1'b1);
    check("resume_tick", sampleTick, 1'b1);
    enable = 1'b0;

    // PRESCALE=4 instance, constant midscale
    rst4 = 1'b0; en4 = 1'b1;
    step();
    check("p4_tick", st4, 1'b1);
    check("p4_duty", duty4, 8'd127);
    t = 0; high = 0; mism = 0;
    do begin
      exp_out = (((t / 4) % 256) < 127);
      if (pwm4 !== exp_out) mism++;
      if (pwm4 === 1'b1) high++;
      t++;
      step();
    end while (st4 !== 1'b1 && t < 3000);
    $display("prescale4 period: len %0d high %0d waveform deviations %0d", t, high, mism);
    check("p4_len", t, 1024);
    check("p4_high", high, 508);
    check("p4_shape", mism, 0);
    check("p4_duty_after", duty4, 8'd127);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_pwm_dac.md
WAVE_PWM_DAC -- requirements
Module: wave_pwm_dac

Interface
REQ-001 SHALL have parameter: PRESCALE, 1, clk cycles per PWM tick (integer 1..256).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: enable  input  1  request PWM operation.
REQ-005 SHALL have port: sel  input  2  source select: 0 sinWave, 1 fullRectifiedWave, 2 halfRectifiedWave, 3 constant 8'd127.
REQ-006 SHALL have port: sinWave  input  8  unsigned offset sine sample from the upstream generator.
REQ-007 SHALL have port: fullRectifiedWave  input  8  full-rectified sample.
REQ-008 SHALL have port: halfRectifiedWave  input  8  half-rectified sample.
REQ-009 SHALL have port: pwmOut  output  1  PWM waveform, to external RC filter.
REQ-010 SHALL have port: sampleTick  output  1  one-cycle pulse per duty latch.
REQ-011 SHALL have port: dutyHeld  output  8  currently held duty value.
REQ-012 SHALL have port: busy  output  1  high when state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, held in a 2-bit state register.
REQ-014 Prescaler SHALL count 0..PRESCALE-1 in RUN/DRAIN; tick = (prescaler == PRESCALE-1); prescaler wraps to 0 on tick.
REQ-015 8-bit pwmCnt SHALL increment on each tick, wrapping 255 -> 0; one PWM period = 256*PRESCALE clk cycles.
REQ-016 IDLE: prescaler = 0, pwmCnt = 0; enable high at an edge -> RUN, dutyHeld <= selected source, sampleTick <= 1.
REQ-017 RUN: enable low -> DRAIN; counting continues uninterrupted.
REQ-018 DRAIN: enable high -> RUN without losing the period; no relatch until the period end.
REQ-019 Period end (tick with pwmCnt == 255): in RUN, relatch dutyHeld from the selected source and pulse sampleTick; in DRAIN -> IDLE, dutyHeld retained.
REQ-020 A DRAIN -> RUN transition coinciding with a period end SHALL be treated as RUN (relatch, pulse).
REQ-021 sampleTick SHALL be registered, high exactly one cycle after each latching edge, otherwise 0.
REQ-022 sel and source inputs SHALL be sampled only at latching edges; mid-period changes have no effect on the current period.
REQ-023 pwmOut SHALL equal (state != IDLE) && (pwmCnt < dutyHeld), decoded from registers only.
REQ-024 Duty 0 -> pwmOut constantly 0; duty 255 -> high for 255 of 256 ticks; duty N -> high for exactly N ticks per period.
REQ-025 busy SHALL equal (state != IDLE).

Reset
REQ-026 rst SHALL, at any time including mid-period, force state IDLE, prescaler 0, pwmCnt 0, dutyHeld 0, sampleTick 0; hence pwmOut 0 and busy 0 in the cycle after the reset edge.
REQ-027 rst SHALL take priority over enable; operation resumes only on a rising clock edge with rst low and enable high.

Structure
REQ-028 State encodings, the sel codes, and the constant MIDSCALE = 8'd127 SHALL live in a shared package, wave_pkg.
REQ-029 The prescaler SHALL be a sub-module, tick_prescaler, with parameter PRESCALE, ports clk, rst, run, tick.
REQ-030 The source multiplexer and the comparator SHALL stay inline in wave_pwm_dac.

Verification
REQ-031 PRESCALE=1, sel=0, sinWave=64, enable held -> pwmOut high 64 of every 256 cycles; sampleTick every 256 cycles.
REQ-032 Duties 0, 1, 255 on successive periods -> 0, 1, and 255 high cycles respectively; no high cycle in the duty-0 period.
REQ-033 Change sel 0->2 and halfRectifiedWave=200 mid-period -> current period unchanged; next period has 200 high cycles.
REQ-034 Drop enable at pwmCnt=100 -> period completes to 255, then IDLE, busy 0; reassert at pwmCnt=150 -> no gap, RUN continues.
REQ-035 Assert rst at pwmCnt=30 with duty 128 -> next cycle pwmOut 0, dutyHeld 0, busy 0, sampleTick 0.
REQ-036 PRESCALE=4, sel=3 -> period 1024 cycles, pwmOut high 508 cycles per period, dutyHeld 127.
